// File: rtl/ccff_pkg.sv
// Shared types and sizing for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StErr
  } state_e;

  // Chain length of sb_0__1_: 14 muxes x 2 config bits.
  localparam int unsigned SB_0__1_CHAIN_LEN = 28;
  localparam int unsigned DEFAULT_DATA_W    = 8;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it LSB first, one bit per cycle, on registered outputs.
module ccff_word_serializer #(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned NbW    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [NbW-1:0]    nbits_i,
  output logic              bit_o,
  output logic              strobe_o,
  output logic              final_bit_o
);

  // word_q holds the bits still to come; head_q is the bit being presented now.
  logic [DATA_W-1:0] word_q, word_d;
  logic [NbW-1:0]    bit_idx_q, bit_idx_d;
  logic [NbW-1:0]    nbits_q, nbits_d;
  logic              active_q, active_d;
  logic              head_q, head_d;

  assign final_bit_o = active_q && (bit_idx_q == nbits_q - NbW'(1));
  assign bit_o       = head_q;
  assign strobe_o    = active_q;

  always_comb begin
    word_d    = word_q;
    bit_idx_d = bit_idx_q;
    nbits_d   = nbits_q;
    active_d  = active_q;
    head_d    = head_q;
    if (load_i) begin
      word_d    = data_i >> 1;
      head_d    = data_i[0];
      bit_idx_d = '0;
      nbits_d   = nbits_i;
      active_d  = 1'b1;
    end else if (active_q && !final_bit_o) begin
      head_d    = word_q[0];
      word_d    = word_q >> 1;
      bit_idx_d = bit_idx_q + NbW'(1);
    end else begin
      active_d = 1'b0;
      head_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q    <= '0;
      bit_idx_q <= '0;
      nbits_q   <= '0;
      active_q  <= 1'b0;
      head_q    <= 1'b0;
    end else begin
      word_q    <= word_d;
      bit_idx_q <= bit_idx_d;
      nbits_q   <= nbits_d;
      active_q  <= active_d;
      head_q    <= head_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a bitstream into a configuration chain, checks its length and the chain tail.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = SB_0__1_CHAIN_LEN,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              err_tail
);

  localparam int unsigned NumWords = ceil_div(CHAIN_LEN, DATA_W);
  localparam int unsigned LastBits = CHAIN_LEN - DATA_W * (NumWords - 1);
  localparam int unsigned CntW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordCntW = $clog2(NumWords + 1);
  localparam int unsigned NbW      = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
  logic                err_tail_q, err_tail_d;
  logic                first_load_q, first_load_d;

  logic                ser_final;
  logic                ser_load;
  logic                accept;
  logic                is_final_word;
  logic                words_left;
  logic                early_last;
  logic [NbW-1:0]      word_nbits;

  assign is_final_word = (word_cnt_q == WordCntW'(NumWords - 1));
  assign words_left    = (word_cnt_q < WordCntW'(NumWords));
  // Ready when the buffer is empty or on its last bit, so words stream without gaps.
  assign s_ready       = (state_q == StLoad) && words_left && (!ccff_shift_en || ser_final);
  assign accept        = s_valid && s_ready;
  // A premature s_last word is dropped rather than pushed into the chain.
  assign early_last    = accept && s_last && !is_final_word;
  assign ser_load      = accept && !early_last;
  assign word_nbits    = is_final_word ? NbW'(LastBits) : NbW'(DATA_W);

  assign busy     = (state_q == StLoad);
  assign done     = done_q;
  assign err_len  = err_len_q;
  assign err_tail = err_tail_q;

  ccff_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk_i       (prog_clk),
    .rst_ni      (pReset),
    .load_i      (ser_load),
    .data_i      (s_data),
    .nbits_i     (word_nbits),
    .bit_o       (ccff_head),
    .strobe_o    (ccff_shift_en),
    .final_bit_o (ser_final)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    last_d       = last_q;
    done_d       = done_q;
    err_len_d    = err_len_q;
    err_tail_d   = err_tail_q;
    first_load_d = first_load_q;

    // The chain powers up all-zero, so any 1 out of it during the first load is a fault.
    if (first_load_q && ccff_shift_en && ccff_tail) begin
      err_tail_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLoad;
          done_d     = 1'b0;
          err_len_d  = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          last_d     = 1'b0;
        end
      end
      StLoad: begin
        if (ccff_shift_en && (bit_cnt_q != CntW'(CHAIN_LEN))) begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        if (accept) begin
          word_cnt_d = word_cnt_q + WordCntW'(1);
          if (is_final_word) begin
            last_d = s_last;
          end
        end
        if (early_last) begin
          state_d      = StErr;
          err_len_d    = 1'b1;
          first_load_d = 1'b0;
        end else if (bit_cnt_d == CntW'(CHAIN_LEN)) begin
          first_load_d = 1'b0;
          if (last_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d   = StErr;
            err_len_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
      err_tail_q   <= 1'b0;
      first_load_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      last_q       <= last_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
      err_tail_q   <= err_tail_d;
      first_load_q <= first_load_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader against a word-level reference model.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 28;
  localparam int DATA_W    = 8;
  localparam int NW        = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int LAST_BITS = CHAIN_LEN - DATA_W * (NW - 1);

  logic              prog_clk  = 1'b0;
  logic              pReset    = 1'b0;
  logic              start     = 1'b0;
  logic [DATA_W-1:0] s_data    = '0;
  logic              s_valid   = 1'b0;
  logic              s_last    = 1'b0;
  logic              ccff_tail = 1'b0;
  logic              s_ready, ccff_head, ccff_shift_en, busy, done, err_len, err_tail;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] wq[$];
  bit                lq[$];
  int                gq[$];
  bit                tq[$];
  bit                tail_idle;
  bit                obs[$];
  bit                exp_bits[$];
  bit                m_first_load;
  bit                m_err_tail;

  ccff_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .DATA_W    (DATA_W)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err_len       (err_len),
    .err_tail      (err_tail)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic apply_reset();
    logic [6:0] outs;
    @(negedge prog_clk);
    pReset = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; ccff_tail = 1'b0;
    #1;
    outs = {s_ready, ccff_head, ccff_shift_en, busy, done, err_len, err_tail};
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL reset_during: outputs=%b expected 0000000", outs);
    end
    repeat (2) @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    outs = {s_ready, ccff_head, ccff_shift_en, busy, done, err_len, err_tail};
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL reset_after: outputs=%b expected 0000000", outs);
    end
    m_first_load = 1'b1;
    m_err_tail   = 1'b0;
  endtask

  // Drives one load from wq/lq/gq/tq and checks it against the word-level model.
  task automatic run_load(input string name, input int abort_at, input bit pulse_at_end);
    bit exp_done, exp_err, exp_tail, count_end, finished;
    int exp_idle, wi, shifts, last_sh, idle, cyc, gap_left, bad;
    logic [6:0] outs;

    exp_bits.delete();
    exp_done = 0; exp_err = 0; exp_idle = 0; count_end = 0;
    for (int i = 0; i < wq.size(); i++) begin
      int nb;
      if (i < NW - 1 && lq[i]) begin
        exp_err = 1;
        break;
      end
      nb = (i == NW - 1) ? LAST_BITS : DATA_W;
      for (int b = 0; b < nb; b++) exp_bits.push_back(wq[i][b]);
      if (i > 0) exp_idle += gq[i];
      if (i == NW - 1) begin
        exp_done  = lq[i];
        exp_err   = !lq[i];
        count_end = 1;
        break;
      end
    end
    exp_tail = m_err_tail;
    if (m_first_load)
      for (int k = 0; k < exp_bits.size(); k++) if (k < tq.size() && tq[k]) exp_tail = 1;

    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    checks++;
    if (!(busy === 1'b1 && done === 1'b0 && err_len === 1'b0)) begin
      errors++;
      $display("FAIL %s/start: busy=%b done=%b err_len=%b expected 1 0 0", name, busy, done,
               err_len);
    end

    obs.delete();
    wi = 0; shifts = 0; last_sh = -1; idle = 0; finished = 0;
    gap_left = (gq.size() > 0) ? gq[0] : 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (ccff_shift_en) begin
        obs.push_back(ccff_head);
        if (last_sh >= 0) idle += cyc - last_sh - 1;
        last_sh = cyc;
        shifts++;
      end
      start = 1'b0;
      if (!busy) begin
        finished = 1;
        break;
      end
      if (abort_at >= 0 && shifts == abort_at) begin
        pReset = 1'b0;
        #1;
        outs = {s_ready, ccff_head, ccff_shift_en, busy, done, err_len, err_tail};
        checks++;
        if (outs !== 7'b0) begin
          errors++;
          $display("FAIL %s/reset_midload: outputs=%b expected 0000000", name, outs);
        end
        s_valid = 1'b0; s_last = 1'b0; ccff_tail = 1'b0;
        @(negedge prog_clk); pReset = 1'b1;
        m_first_load = 1'b1;
        m_err_tail   = 1'b0;
        @(negedge prog_clk);
        return;
      end
      ccff_tail = ccff_shift_en ? ((shifts - 1 < tq.size()) ? tq[shifts-1] : 1'b0) : tail_idle;
      if (pulse_at_end && ccff_shift_en && shifts == exp_bits.size()) start = 1'b1;
      if (wi < wq.size() && gap_left > 0) begin
        s_valid = 1'b0;
        if (s_ready) gap_left--;
      end else if (wi < wq.size()) begin
        s_valid = 1'b1; s_data = wq[wi]; s_last = lq[wi];
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready) begin
        wi++;
        gap_left = (wi < gq.size()) ? gq[wi] : 0;
      end
      @(negedge prog_clk);
    end
    s_valid = 1'b0; s_last = 1'b0; ccff_tail = 1'b0;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s/timeout: busy still 1 after 400 cycles, expected 0", name);
    end
    checks++;
    if (obs.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL %s/shift_count: got %0d expected %0d", name, obs.size(), exp_bits.size());
    end
    bad = 0;
    for (int k = 0; k < obs.size() && k < exp_bits.size(); k++) if (obs[k] !== exp_bits[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s/head_seq: got %0d wrong bits expected 0", name, bad);
    end
    checks++;
    if (idle != exp_idle) begin
      errors++;
      $display("FAIL %s/shift_gaps: got %0d idle cycles expected %0d", name, idle, exp_idle);
    end
    checks++;
    if (done !== exp_done || err_len !== exp_err) begin
      errors++;
      $display("FAIL %s/status: done=%b err_len=%b expected %b %b", name, done, err_len,
               exp_done, exp_err);
    end
    checks++;
    if (err_tail !== exp_tail) begin
      errors++;
      $display("FAIL %s/err_tail: got %b expected %b", name, err_tail, exp_tail);
    end
    checks++;
    if (s_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL %s/quiet_after: s_ready=%b shift_en=%b expected 0 0", name, s_ready,
               ccff_shift_en);
    end
    if (count_end) begin
      checks++;
      if (cyc - last_sh != 1) begin
        errors++;
        $display("FAIL %s/latency: got %0d cycles after last shift expected 1", name,
                 cyc - last_sh);
      end
    end
    m_first_load = 1'b0;
    m_err_tail   = exp_tail;
  endtask

  task automatic set_basic();
    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h09};
    lq = '{0, 0, 0, 1};
    gq = '{0, 0, 0, 0};
    tq.delete();
    tail_idle = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    s_valid = 1'b1; s_data = 8'h55;
    repeat (4) @(negedge prog_clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b s_ready=%b shift_en=%b expected 0 0 0", busy,
               s_ready, ccff_shift_en);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [27:0] spec_seq;
    logic [27:0] got_seq;
    apply_reset();
    set_basic();
    run_load("basic", -1, 0);
    spec_seq = 28'b1010010100111100111111111001;
    got_seq  = '0;
    for (int k = 0; k < obs.size() && k < 28; k++) got_seq[27-k] = obs[k];
    checks++;
    if (got_seq !== spec_seq) begin
      errors++;
      $display("FAIL basic/literal_seq: got %b expected %b", got_seq, spec_seq);
    end
    repeat (5) @(negedge prog_clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic/done_held: done=%b busy=%b expected 1 0", done, busy);
    end
  endtask

  task automatic test_gap();
    set_basic();
    gq = '{0, 3, 0, 0};
    run_load("gap", -1, 0);
  endtask

  task automatic test_early_last();
    set_basic();
    lq = '{0, 0, 1, 0};
    run_load("early_last", -1, 0);
  endtask

  task automatic test_long_stream();
    set_basic();
    wq.push_back(8'h77);
    lq = '{0, 0, 0, 0, 1};
    gq.push_back(0);
    run_load("long_stream", -1, 0);
  endtask

  task automatic test_tail();
    apply_reset();
    set_basic();
    for (int k = 0; k < CHAIN_LEN; k++) tq.push_back(k == 4);
    run_load("tail_first", -1, 0);
    tq.delete();
    for (int k = 0; k < CHAIN_LEN; k++) tq.push_back(k[0]);
    tail_idle = 1'b1;
    run_load("tail_second", -1, 0);
    apply_reset();
    set_basic();
    run_load("tail_clean", -1, 0);
    for (int k = 0; k < CHAIN_LEN; k++) tq.push_back(k[0]);
    run_load("tail_not_first", -1, 0);
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    set_basic();
    run_load("abort", 12, 0);
    repeat (4) @(negedge prog_clk);
    checks++;
    if (busy !== 1'b0 || ccff_shift_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort/idle: busy=%b shift_en=%b done=%b expected 0 0 0", busy,
               ccff_shift_en, done);
    end
    for (int k = 0; k < CHAIN_LEN; k++) tq.push_back(k == 20);
    run_load("after_abort", -1, 0);
  endtask

  task automatic test_back_to_back();
    set_basic();
    run_load("b2b_first", -1, 1);
    @(negedge prog_clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b/start_ignored: busy=%b done=%b expected 0 1", busy, done);
    end
    wq = '{8'h12, 8'h34, 8'h56, 8'h0F};
    run_load("b2b_second", -1, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int scen, nwords;
      scen = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) apply_reset();
      wq.delete(); lq.delete(); gq.delete(); tq.delete();
      nwords = (scen == 2) ? NW + $urandom_range(0, 2) : NW;
      for (int i = 0; i < nwords; i++) begin
        wq.push_back(DATA_W'($urandom));
        lq.push_back(1'b0);
        gq.push_back($urandom_range(0, 3));
      end
      if (scen == 0) lq[NW-1] = 1'b1;
      else if (scen == 1) lq[$urandom_range(0, NW - 2)] = 1'b1;
      else if (nwords > NW) lq[nwords-1] = 1'b1;
      for (int k = 0; k < CHAIN_LEN; k++) tq.push_back($urandom_range(0, 15) == 0);
      tail_idle = 1'($urandom_range(0, 1));
      run_load($sformatf("rand%0d", it), -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_early_last();
    test_long_stream();
    test_tail();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
